// File: rtl/imem_loader.sv
// Instruction memory loader: packs a little-endian byte stream into 32-bit words
// and writes them from BASE_ADDR upward, holding the CPU off while loading.
module imem_loader #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int               MAX_WORDS = 256,
    parameter int               CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_words,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [7:0]           in_byte,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [WIDTH-1:0]     mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 cpu_hold
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WORDS);

    state_t               state_r;
    state_t               next_s;
    logic [CNT_WIDTH-1:0] target_r;
    logic [CNT_WIDTH-1:0] word_cnt_r;
    logic [CNT_WIDTH-1:0] word_inc_s;
    logic [CNT_WIDTH-1:0] clamp_s;
    logic                 over_s;
    logic [1:0]           byte_cnt_r;
    logic [WIDTH-1:0]     addr_r;
    logic [23:0]          collect_r;
    logic                 accept_s;
    logic                 in_ready_r;
    logic                 mem_we_r;
    logic [WIDTH-1:0]     mem_addr_r;
    logic [31:0]          mem_wdata_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;

    // Clamp the requested word count to memory capacity and flag overflow.
    always_comb begin
        clamp_s = num_words;
        over_s  = 1'b0;
        if (num_words > MAX_CNT) begin
            clamp_s = MAX_CNT;
            over_s  = 1'b1;
        end else begin
            clamp_s = num_words;
            over_s  = 1'b0;
        end
    end

    // Handshake qualifier and next word count.
    always_comb begin
        accept_s   = (state_r == COLLECT) && in_valid && !abort;
        word_inc_s = word_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    // Next-state logic; abort outranks a simultaneous byte handshake.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    next_s = (clamp_s == {CNT_WIDTH{1'b0}}) ? DONE : COLLECT;
                end else begin
                    next_s = state_r;
                end
            end
            COLLECT: begin
                if (abort) begin
                    next_s = IDLE;
                end else if (in_valid && (byte_cnt_r == 2'd3)) begin
                    next_s = WRITE;
                end else begin
                    next_s = COLLECT;
                end
            end
            WRITE: begin
                if (abort) begin
                    next_s = IDLE;
                end else if (word_inc_s == target_r) begin
                    next_s = DONE;
                end else begin
                    next_s = COLLECT;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // State register and status outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= next_s;
            in_ready_r <= (next_s == COLLECT);
            mem_we_r   <= (next_s == WRITE);
            busy_r     <= (next_s == COLLECT) || (next_s == WRITE);
            done_r     <= (next_s == DONE);
        end
    end

    // Datapath: counters, byte packing, write address/data capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            target_r    <= {CNT_WIDTH{1'b0}};
            word_cnt_r  <= {CNT_WIDTH{1'b0}};
            byte_cnt_r  <= 2'd0;
            addr_r      <= BASE_ADDR;
            collect_r   <= 24'h00_0000;
            mem_addr_r  <= {WIDTH{1'b0}};
            mem_wdata_r <= 32'h0000_0000;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        target_r   <= clamp_s;
                        err_r      <= over_s;
                        addr_r     <= BASE_ADDR;
                        word_cnt_r <= {CNT_WIDTH{1'b0}};
                        byte_cnt_r <= 2'd0;
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        byte_cnt_r <= 2'd0;
                    end else if (accept_s) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            mem_wdata_r <= {in_byte, collect_r};
                            mem_addr_r  <= addr_r;
                        end else begin
                            collect_r[8*byte_cnt_r +: 8] <= in_byte;
                        end
                    end
                end
                WRITE: begin
                    addr_r     <= addr_r + WIDTH'(4);
                    word_cnt_r <= word_inc_s;
                    byte_cnt_r <= 2'd0;
                end
                default: begin
                    byte_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign cpu_hold  = busy_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus
// and a negedge monitor pops and compares on every mem_we pulse.
module tb_imem_loader;

    localparam int MAXW = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_words = 16'd0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready, mem_we, busy, done, err, cpu_hold;
    logic [31:0] mem_addr, mem_wdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];
    logic prev_we = 1'b0;

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .abort(abort), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err),
        .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e[63:32]);
                check("wr_data", mem_wdata, e[31:0]);
            end
            check("we_single_cycle", {31'd0, prev_we}, 32'd0);
        end
        prev_we = mem_we;
    end

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic start_load(input logic [15:0] n);
        start = 1'b1;
        num_words = n;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_byte = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] w, input int gap);
        exp_q.push_back({a, w});
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [7:0] iv;
        do_reset();
        @(negedge clk);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;

        // Basic load, in_valid held high
        start_load(16'd2);
        check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        send_word(32'h0, 32'h0000_0013, 0);
        send_word(32'h4, 32'h0010_0093, 0);
        wait_done();
        check("hold_at_done", {31'd0, cpu_hold}, 32'd0);

        // Same program with gaps between bytes
        start_load(16'd2);
        check("done_clears", {31'd0, done}, 32'd0);
        send_word(32'h0, 32'h0000_0013, 1);
        send_word(32'h4, 32'h0010_0093, 1);
        wait_done();

        // Zero count
        start_load(16'd0);
        @(negedge clk);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_err", {31'd0, err}, 32'd0);
        check("zero_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // Overflow count: clamped to MAXW writes
        start_load(16'(MAXW + 5));
        check("ovf_err", {31'd0, err}, 32'd1);
        for (int i = 0; i < MAXW; i++) begin
            iv = i[7:0];
            send_word(32'(4 * i), {8'hC3, ~iv, 8'h5A, iv}, 0);
        end
        wait_done();
        check("ovf_last_addr", mem_addr, 32'h0000_03FC);
        check("ovf_err_sticky", {31'd0, err}, 32'd1);

        // Abort after two bytes, then restart
        start_load(16'd2);
        check("err_cleared", {31'd0, err}, 32'd0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        start_load(16'd1);
        send_word(32'h0, 32'hDEAD_BEEF, 0);
        wait_done();

        // Abort during WRITE: the write still happens, then IDLE
        start_load(16'd2);
        send_word(32'h0, 32'h1234_5678, 0);
        abort = 1'b1;
        check("aw_we", {31'd0, mem_we}, 32'd1);
        @(posedge clk);
        #1 abort = 1'b0;
        check("aw_busy", {31'd0, busy}, 32'd0);
        check("aw_done", {31'd0, done}, 32'd0);

        // Reset mid-load after three bytes
        start_load(16'd2);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mr_flags", {24'd0, in_ready, mem_we, busy, done, err, cpu_hold, 2'b00}, 32'd0);
        check("mr_addr", mem_addr, 32'd0);
        check("mr_data", mem_wdata, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        start_load(16'd1);
        send_word(32'h0, 32'h0403_0201, 0);
        wait_done();

        // Start while busy is ignored
        start_load(16'd2);
        exp_q.push_back({32'h0, 32'hA1B2_C3D4});
        send_byte(8'hD4, 0);
        start = 1'b1;
        num_words = 16'd9;
        @(posedge clk);
        #1 start = 1'b0;
        send_byte(8'hC3, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hA1, 0);
        send_word(32'h4, 32'h5566_7788, 0);
        wait_done();

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
